// File: rtl/controle_central.sv
// controle_central: central control unit of the full-nibble processor.
// Decodes the opcode and the ALU overflow flag into registered datapath mux
// selects, a one-cycle memory-dump strobe and a sticky halt flag.
// Optional build macro CTRL_OVF_HALT_EN: an arithmetic opcode with overflow
// also halts the processor at the same edge.
module controle_central (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] op,
  input  logic       ovf,
  output logic       ended,
  output logic       DUMP,
  output logic [1:0] sel_mux1,
  output logic       sel_mux2,
  output logic       sel_mux3
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_ACC  = 3'b011;
  localparam logic [2:0] OP_DUMP = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [1:0] M1_X   = 2'b00;
  localparam logic [1:0] M1_NX  = 2'b01;
  localparam logic [1:0] M1_ONE = 2'b10;

  logic       ended_q, ended_d;
  logic       dump_q, dump_d;
  logic [1:0] sel1_q, sel1_d;
  logic       sel2_q, sel2_d;
  logic       sel3_q, sel3_d;
  logic       arith;

  // Next-state decode of opcode and overflow; halt freezes every select at 0.
  always_comb begin
    ended_d = ended_q;
    dump_d  = 1'b0;
    sel1_d  = M1_X;
    sel2_d  = 1'b0;
    sel3_d  = 1'b0;
    // Opcodes 000-011 all have a clear MSB and drive the ALU.
    arith   = (op[2] == 1'b0);
    if (!ended_q) begin
      unique case (op)
        OP_ADD: begin sel1_d = M1_X;   sel2_d = 1'b0; end
        OP_SUB: begin sel1_d = M1_NX;  sel2_d = 1'b0; end
        OP_INC: begin sel1_d = M1_ONE; sel2_d = 1'b1; end
        OP_ACC: begin sel1_d = M1_X;   sel2_d = 1'b1; end
        OP_DUMP: dump_d  = 1'b1;
        OP_HALT: ended_d = 1'b1;
        default: ; // 101 and 110 are NOPs
      endcase
      // Overflow redirects the write to slot 0xF, only for ALU operations.
      if (arith) begin
        sel3_d = ovf;
`ifdef CTRL_OVF_HALT_EN
        if (ovf) ended_d = 1'b1;
`endif
      end
    end
  end

  // Register all outputs; reset has priority over any opcode, including HALT.
  always_ff @(posedge clk) begin
    if (rst) begin
      ended_q <= 1'b0;
      dump_q  <= 1'b0;
      sel1_q  <= M1_X;
      sel2_q  <= 1'b0;
      sel3_q  <= 1'b0;
    end else begin
      ended_q <= ended_d;
      dump_q  <= dump_d;
      sel1_q  <= sel1_d;
      sel2_q  <= sel2_d;
      sel3_q  <= sel3_d;
    end
  end

  assign ended    = ended_q;
  assign DUMP     = dump_q;
  assign sel_mux1 = sel1_q;
  assign sel_mux2 = sel2_q;
  assign sel_mux3 = sel3_q;

endmodule

// File: tb/tb_controle_central.sv
// Directed testbench for controle_central. Outputs are compared as a packed
// word {ended, DUMP, sel_mux1[1:0], sel_mux2, sel_mux3}.
module tb_controle_central;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] op;
  logic       ovf;
  logic       ended;
  logic       DUMP;
  logic [1:0] sel_mux1;
  logic       sel_mux2;
  logic       sel_mux3;

  int checks = 0;
  int errors = 0;

  controle_central dut (
    .clk      (clk),
    .rst      (rst),
    .op       (op),
    .ovf      (ovf),
    .ended    (ended),
    .DUMP     (DUMP),
    .sel_mux1 (sel_mux1),
    .sel_mux2 (sel_mux2),
    .sel_mux3 (sel_mux3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Apply one input vector across a rising edge, then compare 1 ns later.
  task automatic step(input string tag, input logic r, input logic [2:0] o,
                      input logic v, input logic [5:0] exp);
    rst = r;
    op  = o;
    ovf = v;
    @(posedge clk);
    #1;
    check(tag, {ended, DUMP, sel_mux1, sel_mux2, sel_mux3}, exp);
  endtask

  initial begin
    rst = 1'b1; op = 3'b111; ovf = 1'b1;
    #1;
    // Reset wins over HALT
    step("rst_0",    1'b1, 3'b111, 1'b1, 6'b000000);
    step("rst_1",    1'b1, 3'b111, 1'b1, 6'b000000);
    step("post_rst", 1'b0, 3'b000, 1'b0, 6'b000000);

    // Arithmetic sweep without overflow
    step("add_v0", 1'b0, 3'b000, 1'b0, 6'b000000);
    step("sub_v0", 1'b0, 3'b001, 1'b0, 6'b000100);
    step("inc_v0", 1'b0, 3'b010, 1'b0, 6'b001010);
    step("acc_v0", 1'b0, 3'b011, 1'b0, 6'b000010);

    // Arithmetic sweep with overflow
`ifdef CTRL_OVF_HALT_EN
    step("add_v1", 1'b0, 3'b000, 1'b1, 6'b100001);
    step("sub_v1", 1'b0, 3'b001, 1'b1, 6'b100000);
    step("inc_v1", 1'b0, 3'b010, 1'b1, 6'b100000);
    step("acc_v1", 1'b0, 3'b011, 1'b1, 6'b100000);
`else
    step("add_v1", 1'b0, 3'b000, 1'b1, 6'b000001);
    step("sub_v1", 1'b0, 3'b001, 1'b1, 6'b000101);
    step("inc_v1", 1'b0, 3'b010, 1'b1, 6'b001011);
    step("acc_v1", 1'b0, 3'b011, 1'b1, 6'b000011);
`endif
    step("rst_mid", 1'b1, 3'b000, 1'b0, 6'b000000);

    // DUMP strobe and NOPs
    step("dump_v0",  1'b0, 3'b100, 1'b0, 6'b010000);
    step("nop5",     1'b0, 3'b101, 1'b0, 6'b000000);
    step("dump_v1",  1'b0, 3'b100, 1'b1, 6'b010000);
    step("nop6_v1",  1'b0, 3'b110, 1'b1, 6'b000000);
    step("acc_back", 1'b0, 3'b011, 1'b0, 6'b000010);

    // Halt is sticky and masks everything else
    step("halt",      1'b0, 3'b111, 1'b0, 6'b100000);
    step("h_add_v1",  1'b0, 3'b000, 1'b1, 6'b100000);
    step("h_dump_v1", 1'b0, 3'b100, 1'b1, 6'b100000);
    step("h_inc_v1",  1'b0, 3'b010, 1'b1, 6'b100000);
    step("h_halt",    1'b0, 3'b111, 1'b0, 6'b100000);
    step("h_rst",     1'b1, 3'b111, 1'b1, 6'b000000);
    step("after_rst", 1'b0, 3'b001, 1'b0, 6'b000100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
